// File: rtl/fpmul_io_sequencer.sv
// fpmul_io_sequencer: loads two operands in pad beats, runs the multiplier
// with a timeout and returns the result beat by beat over the pads.
`timescale 1ns/1ps
module fpmul_io_sequencer #(
    parameter int DATA_W      = 16,
    parameter int BEAT_W      = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic [BEAT_W-1:0] pin_data_i,
    input  logic              pin_valid_i,
    output logic              pin_ack_o,
    output logic [BEAT_W-1:0] pin_data_o,
    output logic              pin_rdy_o,
    output logic              pin_busy_o,
    output logic              pin_err_o,
    output logic [DATA_W-1:0] mul_a_o,
    output logic [DATA_W-1:0] mul_b_o,
    output logic              mul_start_o,
    input  logic              mul_done_i,
    input  logic [DATA_W-1:0] mul_result_i
);

    localparam int NBEATS = DATA_W / BEAT_W;
    localparam int BCW    = $clog2(2 * NBEATS + 1);
    localparam int TW     = $clog2(TIMEOUT_CYC + 1);

    localparam logic [BCW-1:0] NB       = BCW'(NBEATS);
    localparam logic [BCW-1:0] LAST_OP  = BCW'(2 * NBEATS - 1);
    localparam logic [BCW-1:0] LAST_RES = BCW'(NBEATS - 1);
    localparam logic [TW-1:0]  T_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]  T_MAX    = TW'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_SEND,
        S_ERR
    } state_t;

    state_t            state_q, state_n;
    logic [BCW-1:0]    cnt_q, cnt_n;
    logic [TW-1:0]     timer_q, timer_n;
    logic              valid_q;
    logic [DATA_W-1:0] res_q, res_n;
    logic [DATA_W-1:0] a_n, b_n;
    logic [BEAT_W-1:0] data_n;
    logic              ack_n, rdy_n, busy_n, err_n, start_n;
    logic              stb_edge, accept;

    assign stb_edge = pin_valid_i & ~valid_q;
    assign accept   = stb_edge & (state_q != S_START) & (state_q != S_WAIT);

    // Next state, datapath captures and next registered outputs
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        timer_n = timer_q;
        res_n   = res_q;
        a_n     = mul_a_o;
        b_n     = mul_b_o;
        err_n   = pin_err_o;
        ack_n   = accept ? 1'b1 : (pin_valid_i & pin_ack_o);
        unique case (state_q)
            S_IDLE: begin
                if (stb_edge) begin
                    a_n[BEAT_W-1:0] = pin_data_i;
                    cnt_n           = BCW'(1);
                    state_n         = S_LOAD;
                end
            end
            S_LOAD: begin
                if (stb_edge) begin
                    if (cnt_q < NB)
                        a_n[cnt_q*BEAT_W +: BEAT_W] = pin_data_i;
                    else
                        b_n[(cnt_q-NB)*BEAT_W +: BEAT_W] = pin_data_i;
                    cnt_n = cnt_q + 1'b1;
                    if (cnt_q == LAST_OP)
                        state_n = S_START;
                end
            end
            S_START: begin
                timer_n = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                timer_n = (timer_q == T_MAX) ? timer_q : timer_q + 1'b1;
                if (mul_done_i) begin
                    res_n   = mul_result_i;
                    cnt_n   = '0;
                    state_n = S_SEND;
                end else if (timer_q == T_LAST) begin
                    err_n   = 1'b1;
                    state_n = S_ERR;
                end
            end
            S_SEND: begin
                if (stb_edge) begin
                    if (cnt_q == LAST_RES) begin
                        cnt_n   = '0;
                        state_n = S_IDLE;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end
            S_ERR: begin
                if (stb_edge) begin
                    err_n   = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        start_n = (state_n == S_START);
        rdy_n   = (state_n == S_SEND);
        busy_n  = (state_n != S_IDLE);
        data_n  = rdy_n ? res_n[cnt_n*BEAT_W +: BEAT_W] : '0;
    end

    // State and output registers; reset aborts any transfer in flight
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            timer_q     <= '0;
            valid_q     <= 1'b1;
            res_q       <= '0;
            mul_a_o     <= '0;
            mul_b_o     <= '0;
            mul_start_o <= 1'b0;
            pin_ack_o   <= 1'b0;
            pin_data_o  <= '0;
            pin_rdy_o   <= 1'b0;
            pin_busy_o  <= 1'b0;
            pin_err_o   <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            timer_q     <= timer_n;
            valid_q     <= pin_valid_i;
            res_q       <= res_n;
            mul_a_o     <= a_n;
            mul_b_o     <= b_n;
            mul_start_o <= start_n;
            pin_ack_o   <= ack_n;
            pin_data_o  <= data_n;
            pin_rdy_o   <= rdy_n;
            pin_busy_o  <= busy_n;
            pin_err_o   <= err_n;
        end
    end

endmodule

// File: tb/tb_fpmul_io_sequencer.sv
// tb_fpmul_io_sequencer: host beat driver, multiplier model and
// scoreboard queues for operands and result beats.
`timescale 1ns/1ps
module tb_fpmul_io_sequencer;

    localparam int DW = 16;
    localparam int BW = 8;
    localparam int TO = 64;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_n = 1'b0;
    logic [BW-1:0] pin_data_i = '0;
    logic          pin_valid_i = 1'b1;
    logic          pin_ack_o;
    logic [BW-1:0] pin_data_o;
    logic          pin_rdy_o;
    logic          pin_busy_o;
    logic          pin_err_o;
    logic [DW-1:0] mul_a_o;
    logic [DW-1:0] mul_b_o;
    logic          mul_start_o;
    logic          mul_done_i = 1'b0;
    logic [DW-1:0] mul_result_i = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0]   op_q[$];
    logic [7:0]    beat_q[$];
    logic [31:0]   mon_exp;

    int            model_dly = -1;
    logic [DW-1:0] model_res = '0;
    int            mcnt = 0;
    logic          mbusy = 1'b0;
    int            n;

    always #5 wb_clk_i = ~wb_clk_i;

    fpmul_io_sequencer #(
        .DATA_W(DW),
        .BEAT_W(BW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .wb_clk_i(wb_clk_i),
        .wb_rst_n(wb_rst_n),
        .pin_data_i(pin_data_i),
        .pin_valid_i(pin_valid_i),
        .pin_ack_o(pin_ack_o),
        .pin_data_o(pin_data_o),
        .pin_rdy_o(pin_rdy_o),
        .pin_busy_o(pin_busy_o),
        .pin_err_o(pin_err_o),
        .mul_a_o(mul_a_o),
        .mul_b_o(mul_b_o),
        .mul_start_o(mul_start_o),
        .mul_done_i(mul_done_i),
        .mul_result_i(mul_result_i)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge wb_clk_i);
        #1;
    endtask

    // Multiplier model: answers model_dly cycles after the start cycle
    always @(posedge wb_clk_i) begin
        #1;
        mul_done_i = 1'b0;
        if (!wb_rst_n) begin
            mbusy = 1'b0;
        end else if (mul_start_o) begin
            mbusy = 1'b1;
            mcnt  = 0;
        end else if (mbusy) begin
            mcnt++;
            if (mcnt == model_dly) begin
                mul_done_i   = 1'b1;
                mul_result_i = model_res;
                mbusy        = 1'b0;
                beat_q.push_back(model_res[7:0]);
                beat_q.push_back(model_res[15:8]);
            end
        end
    end

    // Operand scoreboard: checked whenever the start pulse is seen
    always @(posedge wb_clk_i) begin
        #1;
        if (wb_rst_n && mul_start_o) begin
            chk("op_avail", 32'(op_q.size() > 0), 1);
            if (op_q.size() > 0) begin
                mon_exp = op_q.pop_front();
                chk("mul_a", mul_a_o, mon_exp[31:16]);
                chk("mul_b", mul_b_o, mon_exp[15:0]);
            end
        end
    end

    task automatic beat(input logic [7:0] d, input logic exp_ack,
                        input logic exp_start);
        pin_data_i  = d;
        pin_valid_i = 1'b1;
        tick;
        chk("ack", pin_ack_o, exp_ack);
        chk("start", mul_start_o, exp_start);
        pin_valid_i = 1'b0;
        tick;
        chk("ack_drop", pin_ack_o, 0);
        chk("start_off", mul_start_o, 0);
    endtask

    task automatic load_op(input logic [15:0] a, input logic [15:0] b);
        op_q.push_back({a, b});
        beat(a[7:0], 1'b1, 1'b0);
        beat(a[15:8], 1'b1, 1'b0);
        beat(b[7:0], 1'b1, 1'b0);
        beat(b[15:8], 1'b1, 1'b1);
    endtask

    task automatic wait_rdy(output int cyc);
        cyc = 0;
        while (!pin_rdy_o && cyc < 300) begin
            tick;
            cyc++;
        end
        chk("rdy_seen", pin_rdy_o, 1);
    endtask

    task automatic read_beat;
        logic [7:0] e;
        chk("rd_rdy", pin_rdy_o, 1);
        chk("beat_avail", 32'(beat_q.size() > 0), 1);
        e = 8'h00;
        if (beat_q.size() > 0)
            e = beat_q.pop_front();
        chk("rd_data", pin_data_o, e);
        beat(8'h5A, 1'b1, 1'b0);
    endtask

    task automatic check_idle;
        chk("idle_busy", pin_busy_o, 0);
        chk("idle_rdy", pin_rdy_o, 0);
        chk("idle_data", pin_data_o, 0);
    endtask

    initial begin
        // Reset held with strobe high
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rst_ctl", {pin_ack_o, pin_data_o, pin_rdy_o, pin_busy_o,
                            pin_err_o, mul_start_o}, 0);
            chk("rst_a", mul_a_o, 0);
            chk("rst_b", mul_b_o, 0);
        end
        wb_rst_n = 1'b1;
        tick;
        tick;
        chk("held_busy", pin_busy_o, 0);
        chk("held_ack", pin_ack_o, 0);
        pin_valid_i = 1'b0;
        tick;

        // Basic operation, 5-cycle multiplier
        model_dly = 5;
        model_res = 16'h4000;
        load_op(16'h3C00, 16'h4000);
        wait_rdy(n);
        chk("rdy_lat", n, 5);
        read_beat;
        read_beat;
        check_idle;

        // Timeout and error clear
        model_dly = -1;
        load_op(16'h0201, 16'h0403);
        n = 0;
        while (!pin_err_o && n < 300) begin
            tick;
            n++;
        end
        chk("err_lat", n, TO);
        chk("err_rdy", pin_rdy_o, 0);
        chk("err_busy", pin_busy_o, 1);
        tick;
        chk("err_sticky", pin_err_o, 1);
        beat(8'h99, 1'b1, 1'b0);
        chk("err_clr", pin_err_o, 0);
        chk("err_idle", pin_busy_o, 0);
        chk("err_a", mul_a_o, 16'h0201);
        chk("err_b", mul_b_o, 16'h0403);

        // Long strobe in LOAD, edges ignored in WAIT
        model_dly = 20;
        model_res = 16'h1234;
        pin_data_i  = 8'h55;
        pin_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (i == 3)
                pin_data_i = 8'hEE;
            chk("hold_ack", pin_ack_o, 1);
            chk("hold_busy", pin_busy_o, 1);
        end
        pin_valid_i = 1'b0;
        tick;
        chk("hold_drop", pin_ack_o, 0);
        op_q.push_back({16'h6655, 16'h8877});
        beat(8'h66, 1'b1, 1'b0);
        beat(8'h77, 1'b1, 1'b0);
        beat(8'h88, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            pin_data_i  = 8'hF0;
            pin_valid_i = 1'b1;
            tick;
            chk("wait_ack", pin_ack_o, 0);
            pin_valid_i = 1'b0;
            tick;
            chk("wait_ack_lo", pin_ack_o, 0);
        end
        chk("wait_a", mul_a_o, 16'h6655);
        chk("wait_b", mul_b_o, 16'h8877);
        chk("wait_busy", pin_busy_o, 1);
        wait_rdy(n);
        read_beat;
        read_beat;
        check_idle;

        // Reset in the middle of operand load
        model_dly = 3;
        model_res = 16'hBEEF;
        beat(8'hAA, 1'b1, 1'b0);
        beat(8'hBB, 1'b1, 1'b0);
        wb_rst_n = 1'b0;
        tick;
        chk("mid_rst_busy", pin_busy_o, 0);
        chk("mid_rst_a", mul_a_o, 0);
        tick;
        wb_rst_n = 1'b1;
        tick;
        load_op(16'h2211, 16'h4433);
        wait_rdy(n);
        read_beat;
        read_beat;
        check_idle;

        // Done in the last timer cycle beats the timeout
        model_dly = TO;
        model_res = 16'hCAFE;
        load_op(16'h0605, 16'h0807);
        wait_rdy(n);
        chk("late_lat", n, TO);
        chk("late_err", pin_err_o, 0);
        read_beat;
        read_beat;
        chk("late_err2", pin_err_o, 0);
        check_idle;

        chk("op_q_left", op_q.size(), 0);
        chk("beat_q_left", beat_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
